ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline: sits directly downstream of the decode stage and upstream of the memory stage. Contains the ID/EX pipeline register, the ALU, destination-register selection, branch/jump target generation and branch resolution. All results are registered once at the stage input and produced combinationally from that register for the memory stage.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.
- `LINK_REG`, 31: destination register for `jal`.

Ports:
- `CLK`  in  1  clock. Every register updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `flush`  in  1  from the memory stage; loads a bubble into ID/EX.
- `PCPlus4_in`, `imm_signExtended`, `imm_zeroExtended`, `rs_reg`, `rt_reg`  in  32 each  decode-stage operands.
- `rt_addr_in`, `rd_addr_in`, `shamt_in`  in  5 each  instruction fields.
- `address_Jtype_in`  in  26  J-type target field.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `BranchD`, `JumpD`, `RegDstD`  in  1 each  decode control signals.
- `ALUopD`, `ALUfunctD`  in  6 each  opcode and funct.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `JumpE`  out  1 each  registered controls; `RegWriteE` is gated by overflow.
- `ALUOutE`  out  32  ALU result, memory address, or link value.
- `WriteDataE`  out  32  registered `rt_reg`, used as store data.
- `WriteRegE`  out  5  destination register.
- `BranchTakenE`  out  1  resolved `beq`/`bne`.
- `PCBranchE`, `PCJumpE`  out  32  redirect targets.
- `OverflowE`  out  1  signed overflow on `add`, `addi` or `sub`.

## Operation
- ID/EX register holds every `*_in`/`*D` input. On each rising edge of `CLK` it loads the inputs, or all zeros when `flush` = 1. The all-zero value decodes as `sll $0,$0,0` with all controls 0, i.e. a bubble.
- ALU operand A is `rs`.
- ALU operand B:
  - `imm_zeroExtended` for `andi`, `ori`, `xori`;
  - `imm_signExtended` for `addi`, `addiu`, `lw`, `sw`;
  - otherwise `rt`.
- ALU operations:
  - add-type (`add`, `addu`, `addi`, `addiu`, `lw`, `sw`): A+B, mod 2^32.
  - subtract-type (`sub`, `subu`): A−B, mod 2^32.
  - logical: `and`/`andi`, `or`/`ori`, `xor`/`xori`, `nor`.
  - `slt`: 1 when rs < rt as signed values, else 0.
  - fixed shifts: `sll`, `srl`, `sra` shift `rt` by `shamt`.
  - variable shifts: `sllv`, `srlv`, `srav` shift `rt` by `rs[4:0]`. `sra`/`srav` are arithmetic.
  - `jal`: `ALUOutE` = registered `PCPlus4`.
  - any unrecognised op/funct: `ALUOutE` = 0.
- `WriteRegE`:
  - `LINK_REG` for `jal`;
  - else `rd` when `RegDst` = 1;
  - else `rt`.
- `PCBranchE` = `PCPlus4` + (`imm_signExtended` << 2), mod 2^32.
- `PCJumpE`:
  - `rs` for `jr` (op 0, funct 001000);
  - else {`PCPlus4[31:28]`, `address_Jtype`, 2'b00}.
- `BranchTakenE` = `Branch` AND (rs == rt for `beq`; rs != rt for `bne`).
- `OverflowE` = 1 when the operand signs agree (`add`/`addi`) or differ (`sub`) and the result sign differs from A. When `OverflowE` = 1, `RegWriteE` is forced to 0 and `ALUOutE` still shows the wrapped sum. `addu`, `addiu` and `subu` never flag overflow.

## Timing
- Latency: exactly one cycle. Inputs present before edge N appear at the outputs after edge N, settling combinationally within the same cycle.
- Reset (`RST_N` = 0) clears the register asynchronously, at any time including mid-instruction. Every output is then 0: controls, `ALUOutE`, `WriteDataE`, `WriteRegE`, `PCBranchE`, `PCJumpE`, `BranchTakenE`, `OverflowE`. Release is synchronous to the next `CLK` edge; the first capture happens at the first edge with `RST_N` = 1.
- `flush` is sampled only at the rising edge, with no delay-based sampling. If `flush` = 1 at the same edge that new valid inputs are presented, `flush` wins and those inputs are discarded.
- No stall input: the register loads on every edge.

## Structure
- Shared package `cpu_pkg` holds the opcode and funct constants, the `LINK_REG` default, and the `alu_ctrl_e` enum. The decode stage and this block both import it.
- One combinational sub-module, `alu`, takes A, B, shift amount and `alu_ctrl_e`, and produces the result and overflow. Operand muxing, target generation and the pipeline register stay in `ex_stage`.

## Test plan
- Reset mid-run: assert `RST_N` = 0 while an `add` is in flight → all outputs 0 immediately, without waiting for a clock edge.
- `add` with rs = 0x7FFFFFFF, rt = 1 → `ALUOutE` = 0x80000000, `OverflowE` = 1, `RegWriteE` = 0.
- `addu` with the same operands → `ALUOutE` = 0x80000000, `OverflowE` = 0, `RegWriteE` = 1.
- `srav` with rt = 0x80000000, rs = 0x24 → shift by 4, `ALUOutE` = 0xF8000000.
- `slt` with rs = 0xFFFFFFFF, rt = 1 → `ALUOutE` = 1.
- `andi` with imm_zero = 0x0000FFFF, rs = 0x12345678 → `ALUOutE` = 0x00005678.
- `bne` with PCPlus4 = 0x100, imm = 0xFFFFFFFE, rs = 3, rt = 4 → `PCBranchE` = 0xF8, `BranchTakenE` = 1. Same operands with `beq` → `BranchTakenE` = 0.
- `jal` with PCPlus4 = 0x40000010, addr = 0x0000040 → `PCJumpE` = 0x40000100, `ALUOutE` = 0x40000010, `WriteRegE` = 31, `RegWriteE` = 1.
- `jr` with rs = 0x1234 → `PCJumpE` = 0x1234.
- `lw` presented together with `flush` = 1 at the same edge → next cycle all controls 0 and `WriteRegE` = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MIPS decode constants and execute-stage types.
// Imported by the decode stage, ex_stage and alu.
package cpu_pkg;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;

  localparam logic [4:0] DefaultLinkReg = 5'd31;

  typedef enum logic [3:0] {
    AluNone, AluAdd, AluAddu, AluSub, AluSubu, AluAnd, AluOr, AluXor,
    AluNor, AluSlt, AluSll, AluSrl, AluSra
  } alu_ctrl_e;

  // ID/EX pipeline register contents; all-zero is a bubble (sll $0,$0,0).
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [25:0] addr_j;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        reg_dst;
    logic [5:0]  op;
    logic [5:0]  funct;
  } idex_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage.
// Ports: a, b operands; shamt shift amount; ctrl operation select;
//        result; overflow (signed overflow for AluAdd/AluSub only).
module alu
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  alu_ctrl_e       ctrl,
  output logic [XLEN-1:0] result,
  output logic            overflow
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (ctrl)
      AluAdd: begin
        result   = sum;
        overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      AluAddu: result = sum;
      AluSub: begin
        result   = diff;
        overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      AluSubu: result = diff;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluNor:  result = ~(a | b);
      AluSlt:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      AluSll:  result = b << shamt;
      AluSrl:  result = b >> shamt;
      AluSra:  result = $signed(b) >>> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand selection, ALU, destination
// select, branch/jump targets and branch resolution.
// Inputs: decode-stage operands, instruction fields and controls, flush.
// Outputs: registered controls (RegWriteE gated by overflow), ALUOutE,
//          WriteDataE, WriteRegE, BranchTakenE, PCBranchE, PCJumpE, OverflowE.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [4:0]  LINK_REG = DefaultLinkReg
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            flush,
  input  logic [XLEN-1:0] PCPlus4_in,
  input  logic [XLEN-1:0] imm_signExtended,
  input  logic [XLEN-1:0] imm_zeroExtended,
  input  logic [XLEN-1:0] rs_reg,
  input  logic [XLEN-1:0] rt_reg,
  input  logic [4:0]      rt_addr_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [4:0]      shamt_in,
  input  logic [25:0]     address_Jtype_in,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            RegDstD,
  input  logic [5:0]      ALUopD,
  input  logic [5:0]      ALUfunctD,
  output logic            RegWriteE,
  output logic            MemtoRegE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic [XLEN-1:0] ALUOutE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [4:0]      WriteRegE,
  output logic            BranchTakenE,
  output logic [XLEN-1:0] PCBranchE,
  output logic [XLEN-1:0] PCJumpE,
  output logic            OverflowE
);

  idex_t idex_d, idex_q;

  always_comb begin
    idex_d            = '0;
    idex_d.pc_plus4   = PCPlus4_in;
    idex_d.imm_s      = imm_signExtended;
    idex_d.imm_z      = imm_zeroExtended;
    idex_d.rs         = rs_reg;
    idex_d.rt         = rt_reg;
    idex_d.rt_addr    = rt_addr_in;
    idex_d.rd_addr    = rd_addr_in;
    idex_d.shamt      = shamt_in;
    idex_d.addr_j     = address_Jtype_in;
    idex_d.reg_write  = RegWriteD;
    idex_d.mem_to_reg = MemtoRegD;
    idex_d.mem_write  = MemWriteD;
    idex_d.branch     = BranchD;
    idex_d.jump       = JumpD;
    idex_d.reg_dst    = RegDstD;
    idex_d.op         = ALUopD;
    idex_d.funct      = ALUfunctD;
    if (flush) idex_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  // Decode of the registered instruction into ALU control and operand B.
  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_shamt;
  logic [XLEN-1:0] alu_result;
  logic            alu_ovf;
  logic            is_jal;
  logic            is_jr;

  always_comb begin
    alu_ctrl  = AluNone;
    alu_b     = idex_q.rt;
    alu_shamt = idex_q.shamt;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    case (idex_q.op)
      OpRtype: begin
        case (idex_q.funct)
          FnAdd:  alu_ctrl = AluAdd;
          FnAddu: alu_ctrl = AluAddu;
          FnSub:  alu_ctrl = AluSub;
          FnSubu: alu_ctrl = AluSubu;
          FnAnd:  alu_ctrl = AluAnd;
          FnOr:   alu_ctrl = AluOr;
          FnXor:  alu_ctrl = AluXor;
          FnNor:  alu_ctrl = AluNor;
          FnSlt:  alu_ctrl = AluSlt;
          FnSll:  alu_ctrl = AluSll;
          FnSrl:  alu_ctrl = AluSrl;
          FnSra:  alu_ctrl = AluSra;
          FnSllv: begin alu_ctrl = AluSll; alu_shamt = idex_q.rs[4:0]; end
          FnSrlv: begin alu_ctrl = AluSrl; alu_shamt = idex_q.rs[4:0]; end
          FnSrav: begin alu_ctrl = AluSra; alu_shamt = idex_q.rs[4:0]; end
          FnJr:   is_jr = 1'b1;
          default: alu_ctrl = AluNone;
        endcase
      end
      OpAddi:            begin alu_ctrl = AluAdd;  alu_b = idex_q.imm_s; end
      OpAddiu, OpLw, OpSw: begin alu_ctrl = AluAddu; alu_b = idex_q.imm_s; end
      OpAndi:            begin alu_ctrl = AluAnd;  alu_b = idex_q.imm_z; end
      OpOri:             begin alu_ctrl = AluOr;   alu_b = idex_q.imm_z; end
      OpXori:            begin alu_ctrl = AluXor;  alu_b = idex_q.imm_z; end
      OpJal:             is_jal = 1'b1;
      default:           alu_ctrl = AluNone;
    endcase
  end

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a        (idex_q.rs),
    .b        (alu_b),
    .shamt    (alu_shamt),
    .ctrl     (alu_ctrl),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  logic rs_eq_rt;
  assign rs_eq_rt = (idex_q.rs == idex_q.rt);

  assign OverflowE    = alu_ovf;
  assign RegWriteE    = idex_q.reg_write & ~alu_ovf;
  assign MemtoRegE    = idex_q.mem_to_reg;
  assign MemWriteE    = idex_q.mem_write;
  assign JumpE        = idex_q.jump;
  assign ALUOutE      = is_jal ? idex_q.pc_plus4 : alu_result;
  assign WriteDataE   = idex_q.rt;
  assign WriteRegE    = is_jal ? LINK_REG :
                        (idex_q.reg_dst ? idex_q.rd_addr : idex_q.rt_addr);
  assign PCBranchE    = idex_q.pc_plus4 + {idex_q.imm_s[XLEN-3:0], 2'b00};
  assign PCJumpE      = is_jr ? idex_q.rs :
                        {idex_q.pc_plus4[XLEN-1 -: 4], idex_q.addr_j, 2'b00};
  assign BranchTakenE = idex_q.branch &
                        (((idex_q.op == OpBeq) & rs_eq_rt) |
                         ((idex_q.op == OpBne) & ~rs_eq_rt));

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        flush;
  logic [31:0] PCPlus4_in, imm_signExtended, imm_zeroExtended, rs_reg, rt_reg;
  logic [4:0]  rt_addr_in, rd_addr_in, shamt_in;
  logic [25:0] address_Jtype_in;
  logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD;
  logic [5:0]  ALUopD, ALUfunctD;
  logic        RegWriteE, MemtoRegE, MemWriteE, JumpE;
  logic [31:0] ALUOutE, WriteDataE, PCBranchE, PCJumpE;
  logic [4:0]  WriteRegE;
  logic        BranchTakenE, OverflowE;

  int n_total = 0;
  int n_pass  = 0;

  ex_stage dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .PCPlus4_in(PCPlus4_in), .imm_signExtended(imm_signExtended),
    .imm_zeroExtended(imm_zeroExtended), .rs_reg(rs_reg), .rt_reg(rt_reg),
    .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in), .shamt_in(shamt_in),
    .address_Jtype_in(address_Jtype_in),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .RegDstD(RegDstD),
    .ALUopD(ALUopD), .ALUfunctD(ALUfunctD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .BranchTakenE(BranchTakenE),
    .PCBranchE(PCBranchE), .PCJumpE(PCJumpE), .OverflowE(OverflowE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".RegWriteE"},    32'(RegWriteE),    32'd0);
    check({tag, ".MemtoRegE"},    32'(MemtoRegE),    32'd0);
    check({tag, ".MemWriteE"},    32'(MemWriteE),    32'd0);
    check({tag, ".JumpE"},        32'(JumpE),        32'd0);
    check({tag, ".ALUOutE"},      ALUOutE,           32'd0);
    check({tag, ".WriteDataE"},   WriteDataE,        32'd0);
    check({tag, ".WriteRegE"},    32'(WriteRegE),    32'd0);
    check({tag, ".BranchTakenE"}, 32'(BranchTakenE), 32'd0);
    check({tag, ".PCBranchE"},    PCBranchE,         32'd0);
    check({tag, ".PCJumpE"},      PCJumpE,           32'd0);
    check({tag, ".OverflowE"},    32'(OverflowE),    32'd0);
  endtask

  task automatic clear_in();
    flush = 0; PCPlus4_in = 0; imm_signExtended = 0; imm_zeroExtended = 0;
    rs_reg = 0; rt_reg = 0; rt_addr_in = 0; rd_addr_in = 0; shamt_in = 0;
    address_Jtype_in = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0;
    BranchD = 0; JumpD = 0; RegDstD = 0; ALUopD = 0; ALUfunctD = 0;
  endtask

  // Capture on the next rising edge, then sample 1ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_add(input logic [5:0] fn);
    clear_in();
    ALUopD = 6'b000000; ALUfunctD = fn;
    rs_reg = 32'h7FFF_FFFF; rt_reg = 32'h1;
    RegWriteD = 1; RegDstD = 1; rd_addr_in = 5'd5; rt_addr_in = 5'd6;
  endtask

  initial begin
    clear_in();
    // Reset held across edges with live inputs: outputs stay zero.
    set_add(6'b100001);
    step();
    step();
    check_all_zero("reset_hold");

    // Release between edges; first capture at next edge.
    RST_N = 1;
    set_add(6'b100000);  // add overflow
    step();
    check("add_ovf.ALUOutE", ALUOutE, 32'h8000_0000);
    check("add_ovf.OverflowE", 32'(OverflowE), 32'd1);
    check("add_ovf.RegWriteE", 32'(RegWriteE), 32'd0);

    // Asynchronous reset mid-cycle with an instruction in flight.
    #2 RST_N = 0;
    #1 check_all_zero("reset_async");
    @(negedge CLK) RST_N = 1;

    set_add(6'b100001);  // addu, no overflow
    step();
    check("addu.ALUOutE", ALUOutE, 32'h8000_0000);
    check("addu.OverflowE", 32'(OverflowE), 32'd0);
    check("addu.RegWriteE", 32'(RegWriteE), 32'd1);
    check("addu.WriteRegE", 32'(WriteRegE), 32'd5);
    check("addu.WriteDataE", WriteDataE, 32'h1);

    clear_in(); ALUfunctD = 6'b100010; rs_reg = 32'h8000_0000; rt_reg = 32'h1;
    RegWriteD = 1;  // sub overflow
    step();
    check("sub_ovf.ALUOutE", ALUOutE, 32'h7FFF_FFFF);
    check("sub_ovf.OverflowE", 32'(OverflowE), 32'd1);
    check("sub_ovf.RegWriteE", 32'(RegWriteE), 32'd0);

    clear_in(); ALUfunctD = 6'b100011; rs_reg = 32'h8000_0000; rt_reg = 32'h1;
    step();  // subu
    check("subu.OverflowE", 32'(OverflowE), 32'd0);

    clear_in(); ALUopD = 6'b001000; rs_reg = 32'h7FFF_FFF0; imm_signExtended = 32'h20;
    RegWriteD = 1;  // addi overflow
    step();
    check("addi_ovf.ALUOutE", ALUOutE, 32'h8000_0010);
    check("addi_ovf.OverflowE", 32'(OverflowE), 32'd1);

    clear_in(); ALUfunctD = 6'b000111; rt_reg = 32'h8000_0000; rs_reg = 32'h24;
    step();  // srav by 4
    check("srav.ALUOutE", ALUOutE, 32'hF800_0000);

    clear_in(); ALUfunctD = 6'b000000; rt_reg = 32'h1; shamt_in = 5'd31;
    step();  // sll
    check("sll.ALUOutE", ALUOutE, 32'h8000_0000);

    clear_in(); ALUfunctD = 6'b000011; rt_reg = 32'h8000_0000; shamt_in = 5'd31;
    step();  // sra
    check("sra.ALUOutE", ALUOutE, 32'hFFFF_FFFF);

    clear_in(); ALUfunctD = 6'b000110; rt_reg = 32'h8000_0000; rs_reg = 32'h3;
    step();  // srlv logical
    check("srlv.ALUOutE", ALUOutE, 32'h1000_0000);

    clear_in(); ALUfunctD = 6'b101010; rs_reg = 32'hFFFF_FFFF; rt_reg = 32'h1;
    step();  // slt signed
    check("slt.ALUOutE", ALUOutE, 32'h1);

    clear_in(); ALUfunctD = 6'b100111; rs_reg = 32'hF0F0_0000; rt_reg = 32'h0000_000F;
    step();  // nor
    check("nor.ALUOutE", ALUOutE, 32'h0F0F_FFF0);

    clear_in(); ALUopD = 6'b001100; imm_zeroExtended = 32'h0000_FFFF;
    imm_signExtended = 32'hFFFF_FFFF; rs_reg = 32'h1234_5678;
    RegWriteD = 1; rt_addr_in = 5'd9; rd_addr_in = 5'd3;
    step();  // andi uses zero-extended immediate, rt destination
    check("andi.ALUOutE", ALUOutE, 32'h0000_5678);
    check("andi.WriteRegE", 32'(WriteRegE), 32'd9);

    clear_in(); ALUfunctD = 6'b111111; rs_reg = 32'h5; rt_reg = 32'h6;
    step();  // unknown funct
    check("unknown.ALUOutE", ALUOutE, 32'h0);

    clear_in(); ALUopD = 6'b000101; BranchD = 1; PCPlus4_in = 32'h100;
    imm_signExtended = 32'hFFFF_FFFE; rs_reg = 32'h3; rt_reg = 32'h4;
    step();  // bne
    check("bne.PCBranchE", PCBranchE, 32'hF8);
    check("bne.BranchTakenE", 32'(BranchTakenE), 32'd1);
    ALUopD = 6'b000100;
    step();  // beq, same operands
    check("beq_ne.BranchTakenE", 32'(BranchTakenE), 32'd0);
    rt_reg = 32'h3;
    step();  // beq, equal operands
    check("beq_eq.BranchTakenE", 32'(BranchTakenE), 32'd1);

    clear_in(); ALUopD = 6'b000011; PCPlus4_in = 32'h4000_0010;
    address_Jtype_in = 26'h0000040; RegWriteD = 1; JumpD = 1; rt_addr_in = 5'd7;
    step();  // jal
    check("jal.PCJumpE", PCJumpE, 32'h4000_0100);
    check("jal.ALUOutE", ALUOutE, 32'h4000_0010);
    check("jal.WriteRegE", 32'(WriteRegE), 32'd31);
    check("jal.RegWriteE", 32'(RegWriteE), 32'd1);
    check("jal.JumpE", 32'(JumpE), 32'd1);

    clear_in(); ALUfunctD = 6'b001000; rs_reg = 32'h1234; JumpD = 1;
    PCPlus4_in = 32'h8000_0000; address_Jtype_in = 26'h3FF_FFFF;
    step();  // jr
    check("jr.PCJumpE", PCJumpE, 32'h1234);

    clear_in(); ALUopD = 6'b100011; rs_reg = 32'h1000; imm_signExtended = 32'hFFFF_FFFC;
    rt_reg = 32'hABCD; RegWriteD = 1; MemtoRegD = 1; rt_addr_in = 5'd8;
    step();  // lw
    check("lw.ALUOutE", ALUOutE, 32'h0000_0FFC);
    check("lw.MemtoRegE", 32'(MemtoRegE), 32'd1);
    check("lw.WriteRegE", 32'(WriteRegE), 32'd8);

    flush = 1;
    step();  // lw discarded by flush
    check("flush.RegWriteE", 32'(RegWriteE), 32'd0);
    check("flush.MemtoRegE", 32'(MemtoRegE), 32'd0);
    check("flush.MemWriteE", 32'(MemWriteE), 32'd0);
    check("flush.JumpE", 32'(JumpE), 32'd0);
    check("flush.WriteRegE", 32'(WriteRegE), 32'd0);
    check("flush.ALUOutE", ALUOutE, 32'd0);

    clear_in(); ALUopD = 6'b101011; rs_reg = 32'h200; imm_signExtended = 32'h8;
    rt_reg = 32'hDEAD_BEEF; MemWriteD = 1;
    step();  // sw
    check("sw.ALUOutE", ALUOutE, 32'h208);
    check("sw.MemWriteE", 32'(MemWriteE), 32'd1);
    check("sw.WriteDataE", WriteDataE, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
